// File: rtl/key_tone_pwm.sv
// key_tone_pwm: debounces KEY_NUM active-low keys and plays a per-key square tone on an active-low buzzer.
// Optional auto-off play timer: define KEY_TONE_PWM_AUTO_OFF_EN.
module key_tone_pwm #(
    parameter int KEY_NUM         = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int BASE_PERIOD     = 100_000,
    parameter int AUTO_OFF_CYCLES = 100_000_000,
    localparam int TW = (KEY_NUM > 1) ? $clog2(KEY_NUM) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [KEY_NUM-1:0] key_in,
    output logic [KEY_NUM-1:0] key_flag,
    output logic [KEY_NUM-1:0] key_state,
    output logic [TW-1:0]      tone_sel,
    output logic               playing,
    output logic               buzzer
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int PW = $clog2(BASE_PERIOD + 1);

    if (KEY_NUM < 1 || KEY_NUM > 8 || DEBOUNCE_CYCLES < 2 ||
        (BASE_PERIOD >> (KEY_NUM - 1)) < 4 || AUTO_OFF_CYCLES < 1) begin : g_bad_cfg
        $error("key_tone_pwm: illegal parameter set");
    end

    // Sync outputs are reset values for the first two edges; arming waits until they carry real samples.
    logic [1:0] vld_pipe_q;
    logic       sync_vld;
    assign sync_vld = vld_pipe_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_pipe_q <= '0;
        else        vld_pipe_q <= {vld_pipe_q[0], 1'b1};
    end

    for (genvar i = 0; i < KEY_NUM; i++) begin : g_key
        logic          s1_q, s2_q, st_q, flg_q, arm_q;
        logic [DW-1:0] cnt_q;

        // A key is armed only once seen released after reset, so keys held through reset never flag.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_q  <= 1'b1;
                s2_q  <= 1'b1;
                st_q  <= 1'b1;
                flg_q <= 1'b0;
                arm_q <= 1'b0;
                cnt_q <= '0;
            end else begin
                s1_q  <= key_in[i];
                s2_q  <= s1_q;
                flg_q <= 1'b0;
                if (sync_vld && s2_q) arm_q <= 1'b1;
                if (s2_q == st_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
                    cnt_q <= '0;
                    st_q  <= s2_q;
                    flg_q <= !s2_q && arm_q;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end

        assign key_state[i] = st_q;
        assign key_flag[i]  = flg_q;
    end

    typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_e;

    state_e         state_q;
    logic [TW-1:0]  tone_sel_q, win_sel;
    logic [PW-1:0]  pcnt_q, per, half;
    logic           buzzer_q, any_flag, timeout;

    always_comb begin
        win_sel = '0;
        for (int i = KEY_NUM - 1; i >= 0; i--)
            if (key_flag[i]) win_sel = TW'(i);
    end

    assign any_flag = |key_flag;
    assign per      = PW'(BASE_PERIOD >> tone_sel_q);
    assign half     = per >> 1;

`ifdef KEY_TONE_PWM_AUTO_OFF_EN
    localparam int TMW = $clog2(AUTO_OFF_CYCLES + 1);
    logic [TMW-1:0] tmr_q;
    assign timeout = (tmr_q == TMW'(AUTO_OFF_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tone_sel_q <= '0;
            pcnt_q     <= '0;
            buzzer_q   <= 1'b1;
`ifdef KEY_TONE_PWM_AUTO_OFF_EN
            tmr_q      <= '0;
`endif
        end else begin
            buzzer_q <= (state_q == PLAY) ? (pcnt_q >= half) : 1'b1;
`ifdef KEY_TONE_PWM_AUTO_OFF_EN
            tmr_q <= (state_q == PLAY && !any_flag) ? tmr_q + 1'b1 : '0;
`endif
            if (state_q == IDLE) begin
                pcnt_q <= '0;
                if (any_flag) begin
                    state_q    <= PLAY;
                    tone_sel_q <= win_sel;
                end
            end else if (any_flag) begin
                // A new tone restarts its period at once; the old one is not finished.
                pcnt_q <= '0;
                if (win_sel == tone_sel_q) state_q    <= IDLE;
                else                       tone_sel_q <= win_sel;
            end else if (timeout) begin
                state_q <= IDLE;
                pcnt_q  <= '0;
            end else begin
                pcnt_q <= (pcnt_q == per - 1'b1) ? '0 : pcnt_q + 1'b1;
            end
        end
    end

    assign tone_sel = tone_sel_q;
    assign playing  = (state_q == PLAY);
    assign buzzer   = buzzer_q;

endmodule

// File: tb/tb_key_tone_pwm.sv
// tb_key_tone_pwm: directed and random key stimulus checked every cycle against a time-based tone model.
module tb_key_tone_pwm;
    localparam int KN   = 4;
    localparam int DB   = 16;
    localparam int BP   = 64;
    localparam int AUTO = 500;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [KN-1:0] key_in;
    logic [KN-1:0] key_flag, key_state;
    logic [1:0]    tone_sel;
    logic          playing, buzzer;

    int n_chk = 0, n_fail = 0, flag_cnt = 0;

    key_tone_pwm #(.KEY_NUM(KN), .DEBOUNCE_CYCLES(DB), .BASE_PERIOD(BP), .AUTO_OFF_CYCLES(AUTO)) dut (
        .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_flag(key_flag), .key_state(key_state),
        .tone_sel(tone_sel), .playing(playing), .buzzer(buzzer)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int per_of(input int s);
        return BP >> s;
    endfunction

    // Reference model: keys by sampled history and stable-run length, tone by elapsed edges since start.
    int            ecount = 0, m_sel = 0, m_start = 0, win = -1;
    int            m_run[KN];
    logic [KN-1:0] m_p1 = '1, m_p2 = '1, m_st = '1, m_flag = '0, m_arm = '0, syn;
    logic          m_play = 1'b0, m_bz = 1'b1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ecount = 0; m_sel = 0; m_start = 0;
            m_p1 = '1; m_p2 = '1; m_st = '1; m_flag = '0; m_arm = '0;
            m_play = 1'b0; m_bz = 1'b1;
            for (int i = 0; i < KN; i++) m_run[i] = 0;
        end else begin
            ecount++;
            if (m_play) m_bz = ((ecount - m_start - 1) % per_of(m_sel)) >= (per_of(m_sel) / 2);
            else        m_bz = 1'b1;
            win = -1;
            for (int i = KN - 1; i >= 0; i--) if (m_flag[i]) win = i;
            if (win >= 0) begin
                if (!m_play)          begin m_play = 1'b1; m_sel = win; m_start = ecount; end
                else if (win == m_sel) m_play = 1'b0;
                else                  begin m_sel = win; m_start = ecount; end
            end
`ifdef KEY_TONE_PWM_AUTO_OFF_EN
            else if (m_play && (ecount - m_start) == AUTO) m_play = 1'b0;
`endif
            syn = m_p2; m_p2 = m_p1; m_p1 = key_in;
            m_flag = '0;
            for (int i = 0; i < KN; i++) begin
                if (syn[i] == m_st[i]) m_run[i] = 0;
                else if (m_run[i] == DB - 1) begin
                    m_run[i] = 0; m_st[i] = syn[i]; m_flag[i] = !syn[i] && m_arm[i];
                end else m_run[i]++;
            end
            if (ecount >= 3) m_arm = m_arm | syn;
        end
    end

    always @(negedge clk) begin
        chk("key_state", key_state, m_st);
        chk("key_flag", key_flag, m_flag);
        chk("playing", playing, m_play);
        chk("buzzer", buzzer, m_bz);
        if (m_play) chk("tone_sel", tone_sel, m_sel);
        flag_cnt += $countones(key_flag);
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_flag(input int k, output int n);
        n = 0;
        do begin step(1); n++; end while (!key_flag[k] && n < 200);
    endtask

    task automatic wait_bz(input logic lvl, input string tag);
        int n = 0;
        while (buzzer !== lvl && n < 300) begin step(1); n++; end
        chk(tag, n < 300, 1);
    endtask

    task automatic run_len(input logic lvl, output int n);
        n = 0;
        while (buzzer === lvl && n < 300) begin step(1); n++; end
    endtask

    task automatic tap(input int k);
        int n;
        key_in[k] = 1'b0; wait_flag(k, n); step(2); key_in = '1; step(30);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, fc0;
        rst_n = 1'b0; key_in = '1;
        step(3);
        chk("rst_key_state", key_state, 4'hF);
        chk("rst_key_flag", key_flag, 0);
        chk("rst_tone_sel", tone_sel, 0);
        chk("rst_playing", playing, 0);
        chk("rst_buzzer", buzzer, 1);
        rst_n = 1'b1;
        step(5);

        // Bounce shorter than the debounce window.
        fc0 = flag_cnt;
        key_in[0] = 1'b0; step(10); key_in[0] = 1'b1; step(5);
        key_in[0] = 1'b0; step(12); key_in[0] = 1'b1; step(30);
        chk("bounce_flags", flag_cnt - fc0, 0);
        chk("bounce_state", key_state, 4'hF);

        // Clean key1 press: latency, tone select, 16/16 duty.
        key_in[1] = 1'b0; wait_flag(1, n);
        chk("press_latency", n, 18);
        step(1);
        chk("press_playing", playing, 1);
        chk("press_sel", tone_sel, 1);
        step(21); key_in[1] = 1'b1;
        wait_bz(1, "k1_align_hi"); wait_bz(0, "k1_align_lo");
        run_len(0, n); chk("k1_low_run", n, 16);
        run_len(1, n); chk("k1_high_run", n, 16);
        step(10);

        // Same key stops, then key3 plays period 8.
        key_in[1] = 1'b0; wait_flag(1, n);
        step(1); chk("stop_playing", playing, 0);
        step(1); chk("stop_buzzer", buzzer, 1);
        key_in = '1; step(30);
        key_in[3] = 1'b0; wait_flag(3, n);
        step(1); chk("k3_sel", tone_sel, 3);
        wait_bz(0, "k3_align_lo");
        run_len(0, n); chk("k3_low_run", n, 4);
        run_len(1, n); chk("k3_high_run", n, 4);
        key_in = '1; step(30);
        tap(3);
        chk("k3_stopped", playing, 0);

        // Keys 2 and 0 together: lowest index wins.
        key_in = 4'b1010; wait_flag(0, n);
        chk("simul_f2", key_flag[2], 1);
        step(1); chk("simul_sel", tone_sel, 0);
        wait_bz(0, "k0_align_lo");
        run_len(0, n); chk("k0_low_run", n, 32);
        run_len(1, n); chk("k0_high_run", n, 32);
        key_in = '1; step(30);
        tap(0);

        // Random key activity, including bounces and overlapping presses.
        for (int s = 0; s < 60; s++) begin
            key_in = 4'($urandom_range(0, 15));
            step($urandom_range(1, 40));
        end
        key_in = '1; step(40);

        // Reset mid-tone with keys held through reset release.
        rst_n = 1'b0; step(2); rst_n = 1'b1; step(5);
        key_in[2] = 1'b0; wait_flag(2, n); step(5);
        key_in[1] = 1'b0; step(3);
        #1 rst_n = 1'b0;
        #1;
        chk("async_playing", playing, 0);
        chk("async_buzzer", buzzer, 1);
        chk("async_flag", key_flag, 0);
        step(3); rst_n = 1'b1;
        fc0 = flag_cnt;
        step(60);
        chk("held_no_flag", flag_cnt - fc0, 0);
        chk("held_playing", playing, 0);
        key_in = '1; step(30);
        key_in[1] = 1'b0; wait_flag(1, n);
        chk("rearm_latency", n, 18);
        step(1); chk("rearm_sel", tone_sel, 1);
        key_in = '1; step(30);
        tap(1);
        chk("pre_auto_idle", playing, 0);

        // Auto-off: no input after the press.
        key_in[2] = 1'b0; wait_flag(2, n); step(1);
        key_in = '1;
        n = 0;
        while (playing && n < 1100) begin step(1); n++; end
`ifdef KEY_TONE_PWM_AUTO_OFF_EN
        chk("auto_off_len", n, AUTO);
`else
        chk("no_auto_off", n, 1100);
`endif
        step(3);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
